// File: rtl/scoreboard_pkg.sv
// Shared definitions for the result scoreboard: state encoding and small helpers.
package scoreboard_pkg;

  localparam logic [0:0] CHECKING = 1'b0;
  localparam logic [0:0] FAILED   = 1'b1;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

  // Increment v, holding at the all-ones value of a w-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] lim;
    lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= lim) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/sb_sync_fifo.sv
// In-order expected-result buffer with same-cycle push/pop and an occupancy count.
module sb_sync_fifo
  import scoreboard_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        wdata,
  output logic [WIDTH-1:0]        rdata,
  output logic [clog2(DEPTH):0]   count
);

  localparam int unsigned AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    do_push = push && ((count != (AW+1)'(DEPTH)) || pop);
    do_pop  = pop && (count != '0);
  end

  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst_n && !clear && do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/result_scoreboard.sv
// Scoreboard comparing a DUT result stream against buffered expected results.
// Optional watchdog enabled by defining SCOREBOARD_TIMEOUT_EN.
module result_scoreboard
  import scoreboard_pkg::*;
#(
  parameter int unsigned WIDTH        = 64,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned STOP_ON_FAIL = 0,
  parameter int unsigned TIMEOUT_CYC  = 1024
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iValid_Nut,
  input  logic [WIDTH-1:0]      iR_nut,
  input  logic                  iValid_Dut,
  input  logic [WIDTH-1:0]      iR_dut,
  input  logic                  iClear,
  output logic                  oGood,
  output logic                  oMismatch,
  output logic                  oOverflow,
  output logic                  oUnderflow,
  output logic                  oTimeout,
  output logic [CNT_W-1:0]      oMatch_Count,
  output logic [CNT_W-1:0]      oMismatch_Count,
  output logic [WIDTH-1:0]      oFirst_Bad_Dut,
  output logic [WIDTH-1:0]      oFirst_Bad_Nut,
  output logic [clog2(DEPTH):0] oPending
);

  localparam int unsigned PW = clog2(DEPTH) + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYC == 0) begin : g_bad_param
    $error("result_scoreboard: DEPTH must be a power of two >= 2 and TIMEOUT_CYC nonzero");
  end

  logic [0:0]       state;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] expected;
  logic             active, empty, full;
  logic             pop, push, bypass, cmp_en, cmp_bad;
  logic             set_ovf, set_unf;
  logic             mis_nx, ovf_nx, unf_nx, tmo_nx;

  sb_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (Clock),
    .rst_n (Reset),
    .clear (iClear),
    .push  (push),
    .pop   (pop),
    .wdata (iR_nut),
    .rdata (head),
    .count (oPending)
  );

  // With an empty buffer a same-cycle NUT value is compared directly and never stored.
  always_comb begin
    active   = (state == CHECKING);
    empty    = (oPending == '0);
    full     = (oPending == PW'(DEPTH));
    pop      = active && iValid_Dut && !empty;
    bypass   = active && iValid_Dut && empty && iValid_Nut;
    push     = active && iValid_Nut && !bypass && (!full || pop);
    expected = empty ? iR_nut : head;
    cmp_en   = pop || bypass;
    cmp_bad  = cmp_en && (iR_dut != expected);
    set_ovf  = active && iValid_Nut && full && !pop;
    set_unf  = active && iValid_Dut && empty && !iValid_Nut;
    mis_nx   = oMismatch || cmp_bad;
    ovf_nx   = oOverflow || set_ovf;
    unf_nx   = oUnderflow || set_unf;
  end

`ifdef SCOREBOARD_TIMEOUT_EN
  logic [31:0] wd;

  always_comb begin
    tmo_nx = oTimeout || (!empty && !iValid_Dut && (wd + 32'd1 == TIMEOUT_CYC));
  end

  always_ff @(posedge Clock) begin
    if (!Reset || iClear) begin
      wd       <= '0;
      oTimeout <= 1'b0;
    end else begin
      oTimeout <= tmo_nx;
      if (iValid_Dut || empty)  wd <= '0;
      else if (wd != TIMEOUT_CYC) wd <= wd + 32'd1;
    end
  end
`else
  assign tmo_nx   = 1'b0;
  assign oTimeout = 1'b0;
`endif

  always_ff @(posedge Clock) begin
    if (!Reset || iClear) begin
      state           <= CHECKING;
      oGood           <= 1'b1;
      oMismatch       <= 1'b0;
      oOverflow       <= 1'b0;
      oUnderflow      <= 1'b0;
      oMatch_Count    <= '0;
      oMismatch_Count <= '0;
      oFirst_Bad_Dut  <= '0;
      oFirst_Bad_Nut  <= '0;
    end else begin
      oMismatch  <= mis_nx;
      oOverflow  <= ovf_nx;
      oUnderflow <= unf_nx;
      oGood      <= !(mis_nx || ovf_nx || unf_nx || tmo_nx);
      if (cmp_bad) begin
        oMismatch_Count <= CNT_W'(sat_inc(64'(oMismatch_Count), CNT_W));
        if (!oMismatch) begin
          oFirst_Bad_Dut <= iR_dut;
          oFirst_Bad_Nut <= expected;
        end
        if (STOP_ON_FAIL != 0) state <= FAILED;
      end else if (cmp_en) begin
        oMatch_Count <= CNT_W'(sat_inc(64'(oMatch_Count), CNT_W));
      end
    end
  end

endmodule

// File: tb/tb_result_scoreboard.sv
// Directed bench: a free-running scoreboard and a stop-on-fail one share one stimulus stream.
module tb_result_scoreboard;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        iValid_Nut = 1'b0;
  logic [63:0] iR_nut = '0;
  logic        iValid_Dut = 1'b0;
  logic [63:0] iR_dut = '0;
  logic        iClear = 1'b0;

  logic        good0, mis0, ovf0, unf0, tmo0;
  logic [15:0] mcnt0, xcnt0;
  logic [63:0] fbd0, fbn0;
  logic [2:0]  pend0;

  logic        good1, mis1, ovf1, unf1, tmo1;
  logic [1:0]  mcnt1, xcnt1;
  logic [63:0] fbd1, fbn1;
  logic [2:0]  pend1;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 Clock = ~Clock;

  result_scoreboard #(
    .WIDTH(64), .DEPTH(4), .CNT_W(16), .STOP_ON_FAIL(0), .TIMEOUT_CYC(16)
  ) u_dut (
    .Clock(Clock), .Reset(Reset), .iValid_Nut(iValid_Nut), .iR_nut(iR_nut),
    .iValid_Dut(iValid_Dut), .iR_dut(iR_dut), .iClear(iClear),
    .oGood(good0), .oMismatch(mis0), .oOverflow(ovf0), .oUnderflow(unf0),
    .oTimeout(tmo0), .oMatch_Count(mcnt0), .oMismatch_Count(xcnt0),
    .oFirst_Bad_Dut(fbd0), .oFirst_Bad_Nut(fbn0), .oPending(pend0)
  );

  result_scoreboard #(
    .WIDTH(64), .DEPTH(4), .CNT_W(2), .STOP_ON_FAIL(1), .TIMEOUT_CYC(1024)
  ) u_stop (
    .Clock(Clock), .Reset(Reset), .iValid_Nut(iValid_Nut), .iR_nut(iR_nut),
    .iValid_Dut(iValid_Dut), .iR_dut(iR_dut), .iClear(iClear),
    .oGood(good1), .oMismatch(mis1), .oOverflow(ovf1), .oUnderflow(unf1),
    .oTimeout(tmo1), .oMatch_Count(mcnt1), .oMismatch_Count(xcnt1),
    .oFirst_Bad_Dut(fbd1), .oFirst_Bad_Nut(fbn1), .oPending(pend1)
  );

  // Drive one cycle of strobes from a negedge; returns at the next negedge.
  task automatic step(input logic vn, input logic [63:0] rn, input logic vd, input logic [63:0] rd);
    iValid_Nut = vn; iR_nut = rn; iValid_Dut = vd; iR_dut = rd;
    @(negedge Clock);
    iValid_Nut = 1'b0; iValid_Dut = 1'b0;
  endtask

  // Clear with strobes present: they must be ignored.
  task automatic pulse_clear();
    iClear = 1'b1;
    step(1'b1, 64'd5, 1'b1, 64'd6);
    iClear = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    checks++; if (good0 !== 1'b1) begin errors++; $display("FAIL reset_good: got %0b expected 1", good0); end
    checks++; if ({mis0, ovf0, unf0, tmo0} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {mis0, ovf0, unf0, tmo0}); end
    checks++; if ({mcnt0, xcnt0} !== 32'd0) begin errors++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", mcnt0, xcnt0); end
    checks++; if (pend0 !== 3'd0) begin errors++; $display("FAIL reset_pending: got %0d expected 0", pend0); end
    checks++; if ({fbd0, fbn0} !== 128'd0) begin errors++; $display("FAIL reset_first_bad: got %0d/%0d expected 0/0", fbd0, fbn0); end
    checks++; if ({good1, mis1, ovf1, unf1, tmo1, mcnt1, xcnt1, pend1} !== 12'b1000_0000_0000) begin
      errors++; $display("FAIL reset_stop_unit: got %b expected 100000000000", {good1, mis1, ovf1, unf1, tmo1, mcnt1, xcnt1, pend1}); end
  endtask

  task automatic test_in_order();
    step(1'b1, 64'd6, 1'b0, 64'd0);
    step(1'b1, 64'd12, 1'b0, 64'd0);
    step(1'b1, 64'd20, 1'b0, 64'd0);
    checks++; if (pend0 !== 3'd3) begin errors++; $display("FAIL order_pending_full: got %0d expected 3", pend0); end
    step(1'b0, 64'd0, 1'b1, 64'd6);
    step(1'b0, 64'd0, 1'b1, 64'd12);
    step(1'b0, 64'd0, 1'b1, 64'd20);
    checks++; if (mcnt0 !== 16'd3) begin errors++; $display("FAIL order_match_count: got %0d expected 3", mcnt0); end
    checks++; if (pend0 !== 3'd0) begin errors++; $display("FAIL order_pending_empty: got %0d expected 0", pend0); end
    checks++; if (good0 !== 1'b1) begin errors++; $display("FAIL order_good: got %0b expected 1", good0); end
  endtask

  task automatic test_mismatch();
    step(1'b1, 64'd42, 1'b0, 64'd0);
    step(1'b0, 64'd0, 1'b1, 64'd41);
    checks++; if (mis0 !== 1'b1) begin errors++; $display("FAIL mis_flag: got %0b expected 1", mis0); end
    checks++; if (xcnt0 !== 16'd1) begin errors++; $display("FAIL mis_count: got %0d expected 1", xcnt0); end
    checks++; if (fbd0 !== 64'd41 || fbn0 !== 64'd42) begin errors++; $display("FAIL mis_first_bad: got %0d/%0d expected 41/42", fbd0, fbn0); end
    checks++; if (good0 !== 1'b0) begin errors++; $display("FAIL mis_good: got %0b expected 0", good0); end
    step(1'b1, 64'd8, 1'b0, 64'd0);
    step(1'b0, 64'd0, 1'b1, 64'd7);
    checks++; if (xcnt0 !== 16'd2) begin errors++; $display("FAIL mis_count2: got %0d expected 2", xcnt0); end
    checks++; if (fbd0 !== 64'd41 || fbn0 !== 64'd42) begin errors++; $display("FAIL mis_first_held: got %0d/%0d expected 41/42", fbd0, fbn0); end
    checks++; if (mcnt0 !== 16'd3) begin errors++; $display("FAIL mis_match_unchanged: got %0d expected 3", mcnt0); end
  endtask

  task automatic test_clear();
    pulse_clear();
    checks++; if ({good0, mis0, ovf0, unf0, xcnt0, mcnt0, pend0} !== {1'b1, 38'd0}) begin
      errors++; $display("FAIL clear_state: got good=%0b mis=%0b m=%0d x=%0d p=%0d expected good=1 rest 0", good0, mis0, mcnt0, xcnt0, pend0); end
    checks++; if ({fbd0, fbn0} !== 128'd0) begin errors++; $display("FAIL clear_first_bad: got %0d/%0d expected 0/0", fbd0, fbn0); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 4; i++) step(1'b1, 64'(i), 1'b0, 64'd0);
    checks++; if (ovf0 !== 1'b0 || pend0 !== 3'd4) begin errors++; $display("FAIL ovf_full_ok: got ovf=%0b p=%0d expected ovf=0 p=4", ovf0, pend0); end
    step(1'b1, 64'd5, 1'b0, 64'd0);
    checks++; if (ovf0 !== 1'b1 || pend0 !== 3'd4) begin errors++; $display("FAIL ovf_set: got ovf=%0b p=%0d expected ovf=1 p=4", ovf0, pend0); end
    checks++; if (good0 !== 1'b0) begin errors++; $display("FAIL ovf_good: got %0b expected 0", good0); end
    step(1'b1, 64'd6, 1'b1, 64'd1);
    checks++; if (pend0 !== 3'd4 || mcnt0 !== 16'd1 || mis0 !== 1'b0) begin
      errors++; $display("FAIL ovf_push_pop: got p=%0d m=%0d mis=%0b expected p=4 m=1 mis=0", pend0, mcnt0, mis0); end
    step(1'b0, 64'd0, 1'b1, 64'd2);
    step(1'b0, 64'd0, 1'b1, 64'd3);
    step(1'b0, 64'd0, 1'b1, 64'd4);
    step(1'b0, 64'd0, 1'b1, 64'd6);
    checks++; if (mcnt0 !== 16'd5 || mis0 !== 1'b0 || pend0 !== 3'd0 || unf0 !== 1'b0) begin
      errors++; $display("FAIL ovf_drain: got m=%0d mis=%0b p=%0d unf=%0b expected m=5 mis=0 p=0 unf=0", mcnt0, mis0, pend0, unf0); end
  endtask

  task automatic test_underflow_bypass();
    pulse_clear();
    step(1'b0, 64'd0, 1'b1, 64'd9);
    checks++; if (unf0 !== 1'b1 || good0 !== 1'b0) begin errors++; $display("FAIL unf_flag: got unf=%0b good=%0b expected 1/0", unf0, good0); end
    checks++; if (mcnt0 !== 16'd0 || xcnt0 !== 16'd0) begin errors++; $display("FAIL unf_counts: got %0d/%0d expected 0/0", mcnt0, xcnt0); end
    pulse_clear();
    step(1'b1, 64'd9, 1'b1, 64'd9);
    checks++; if (mcnt0 !== 16'd1 || pend0 !== 3'd0) begin errors++; $display("FAIL bypass_match: got m=%0d p=%0d expected m=1 p=0", mcnt0, pend0); end
    checks++; if (good0 !== 1'b1 || unf0 !== 1'b0) begin errors++; $display("FAIL bypass_good: got good=%0b unf=%0b expected 1/0", good0, unf0); end
  endtask

  task automatic test_stop_on_fail();
    pulse_clear();
    step(1'b1, 64'd4, 1'b0, 64'd0);
    step(1'b0, 64'd0, 1'b1, 64'd3);
    checks++; if (mis1 !== 1'b1 || xcnt1 !== 2'd1 || fbd1 !== 64'd3 || fbn1 !== 64'd4) begin
      errors++; $display("FAIL stop_first: got mis=%0b x=%0d bad=%0d/%0d expected 1 1 3/4", mis1, xcnt1, fbd1, fbn1); end
    step(1'b1, 64'd10, 1'b0, 64'd0);
    step(1'b0, 64'd0, 1'b1, 64'd10);
    step(1'b1, 64'd11, 1'b1, 64'd11);
    checks++; if (mcnt1 !== 2'd0 || pend1 !== 3'd0) begin errors++; $display("FAIL stop_frozen: got m=%0d p=%0d expected 0/0", mcnt1, pend1); end
    checks++; if (mcnt0 !== 16'd2) begin errors++; $display("FAIL stop_free_unit: got %0d expected 2", mcnt0); end
    pulse_clear();
    checks++; if ({good1, mis1, xcnt1, mcnt1} !== 6'b100000) begin errors++; $display("FAIL stop_clear: got %b expected 100000", {good1, mis1, xcnt1, mcnt1}); end
    step(1'b1, 64'd7, 1'b1, 64'd7);
    checks++; if (mcnt1 !== 2'd1) begin errors++; $display("FAIL stop_rearmed: got %0d expected 1", mcnt1); end
    for (int i = 0; i < 4; i++) step(1'b1, 64'd7, 1'b1, 64'd7);
    checks++; if (mcnt1 !== 2'd3) begin errors++; $display("FAIL sat_match: got %0d expected 3", mcnt1); end
    checks++; if (mcnt0 !== 16'd5) begin errors++; $display("FAIL sat_wide_count: got %0d expected 5", mcnt0); end
  endtask

  task automatic test_timeout();
    pulse_clear();
    step(1'b1, 64'd1, 1'b0, 64'd0);
    repeat (15) @(negedge Clock);
    checks++; if (tmo0 !== 1'b0) begin errors++; $display("FAIL tmo_early: got %0b expected 0", tmo0); end
    @(negedge Clock);
`ifdef SCOREBOARD_TIMEOUT_EN
    checks++; if (tmo0 !== 1'b1 || good0 !== 1'b0) begin errors++; $display("FAIL tmo_set: got tmo=%0b good=%0b expected 1/0", tmo0, good0); end
`else
    checks++; if (tmo0 !== 1'b0 || good0 !== 1'b1) begin errors++; $display("FAIL tmo_disabled: got tmo=%0b good=%0b expected 0/1", tmo0, good0); end
`endif
  endtask

  task automatic test_reset_midop();
    step(1'b1, 64'd2, 1'b0, 64'd0);
    step(1'b0, 64'd0, 1'b1, 64'd3);
    Reset = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
    checks++; if ({good0, mis0, ovf0, unf0, tmo0, mcnt0, xcnt0, pend0} !== {1'b1, 39'd0}) begin
      errors++; $display("FAIL midreset_state: got good=%0b mis=%0b tmo=%0b m=%0d x=%0d p=%0d expected good=1 rest 0", good0, mis0, tmo0, mcnt0, xcnt0, pend0); end
    checks++; if ({fbd0, fbn0} !== 128'd0) begin errors++; $display("FAIL midreset_first_bad: got %0d/%0d expected 0/0", fbd0, fbn0); end
  endtask

  initial begin
    @(negedge Clock);
    test_reset();
    test_in_order();
    test_mismatch();
    test_clear();
    test_overflow();
    test_underflow_bypass();
    test_stop_on_fail();
    test_timeout();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/result_scoreboard.md
Name: result_scoreboard

Overview:
- Parametrised, self-checking successor to the two-input result verificator.
- Compares a DUT result stream against a behavioural-model (NUT) result stream that may arrive earlier by up to DEPTH results.
- Expected results are buffered in order. The block counts matches and mismatches, captures the first failing pair and raises sticky error flags.
- Sits in bench/emulation wrappers beside the multiplier pair. It is synthesisable so it can also be used in FPGA self-test.

Parameters:
- WIDTH, 64, width of compared results.
- DEPTH, 4, expected-result FIFO entries; must be a power of two, at least 2.
- CNT_W, 16, width of match/mismatch counters.
- STOP_ON_FAIL, 0, when 1, comparison stops after the first mismatch (state FAILED).
- TIMEOUT_CYC, 1024, watchdog limit; used only with SCOREBOARD_TIMEOUT_EN.

Ports:
- Clock  in  1  system clock; all logic updates on posedge.
- Reset  in  1  synchronous, active-low reset.
- iValid_Nut  in  1  one-cycle strobe: iR_nut holds a new expected result.
- iR_nut  in  WIDTH  expected result.
- iValid_Dut  in  1  one-cycle strobe: iR_dut holds a new DUT result.
- iR_dut  in  WIDTH  DUT result.
- iClear  in  1  synchronous clear of counters, flags and FIFO; lower priority than Reset.
- oGood  out  1  high while no error flag is set.
- oMismatch  out  1  sticky; set by any compare mismatch.
- oOverflow  out  1  sticky; set by a NUT push into a full FIFO.
- oUnderflow  out  1  sticky; set by a DUT result with no expected result available.
- oTimeout  out  1  sticky watchdog flag; tied 0 without SCOREBOARD_TIMEOUT_EN.
- oMatch_Count  out  CNT_W  matches seen; saturating.
- oMismatch_Count  out  CNT_W  mismatches seen; saturating.
- oFirst_Bad_Dut  out  WIDTH  DUT value of the first mismatch.
- oFirst_Bad_Nut  out  WIDTH  expected value of the first mismatch.
- oPending  out  $clog2(DEPTH)+1  expected results currently buffered.

Behaviour:
- Reset == 0 at posedge:
  - all counters, flags, oFirst_Bad_* and oPending go to 0; FIFO is emptied.
  - oGood = 1; state = CHECKING.
- iClear == 1 (with Reset == 1): same effect as Reset.
- Strobes arriving in the clear cycle are ignored.
- States:
  - CHECKING: normal operation.
  - FAILED: entered on the first mismatch, only when STOP_ON_FAIL == 1. In FAILED, strobes are ignored and counters and FIFO freeze. Exit only via Reset or iClear.
- NUT push: on iValid_Nut, iR_nut is written at the FIFO tail.
- DUT compare, on iValid_Dut:
  - the expected value is the FIFO head if oPending > 0;
  - otherwise it is the same-cycle iR_nut (bypass), when iValid_Nut is also high.
  - The compare is registered: counters, flags and oFirst_Bad_* update at the posedge that samples the strobe, so they are visible the next cycle. Latency is 1.
- Simultaneous push and pop:
  - When oPending > 0, the head is popped and the new value is pushed in the same cycle; oPending is unchanged.
  - A full FIFO with push and pop in the same cycle is legal and does not set oOverflow.
- Overflow: push into a full FIFO with no pop sets oOverflow; the value is dropped and the FIFO is unchanged.
- Underflow: iValid_Dut with oPending == 0 and no iValid_Nut sets oUnderflow. No counter changes.
- Mismatch:
  - oMismatch_Count increments and oMismatch is set.
  - oFirst_Bad_* load only if oMismatch was 0 before that cycle.
- Match: oMatch_Count increments.
- Counters saturate at 2^CNT_W-1; they never wrap.
- oGood = ~(oMismatch | oOverflow | oUnderflow | oTimeout). It is registered and updates in the same cycle as the flags.
- FIFO pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.
- Full/empty are derived from the oPending count.
- Compare is full-width unsigned equality. X/Z on inputs is not handled.

Optional Feature:
- Macro: SCOREBOARD_TIMEOUT_EN.
- Defined:
  - a watchdog counter clears on any iValid_Dut, or while oPending == 0;
  - otherwise it increments each cycle.
  - When it reaches TIMEOUT_CYC, oTimeout is set (sticky) and the counter holds.
- Undefined: no counter logic; oTimeout is constant 0.

Decomposition:
- Package scoreboard_pkg holds:
  - the state encoding (CHECKING = 1'b0, FAILED = 1'b1);
  - a clog2 helper function;
  - a saturating-increment function.
- One natural sub-module, sb_sync_fifo (DEPTH x WIDTH):
  - push/pop interface with count output;
  - same-cycle push+pop support;
  - synchronous active-low reset plus a clear input.

Test Plan:
- Reset held low 3 cycles, then released -> oGood = 1; all counts, flags and oPending = 0.
- NUT pushes 6, 12, 20 on consecutive cycles, then DUT sends 6, 12, 20 -> oMatch_Count = 3, oPending returns 0, oGood stays 1.
- NUT 42, DUT 41 (STOP_ON_FAIL = 0) -> next cycle:
  - oMismatch = 1, oMismatch_Count = 1, oFirst_Bad_Dut = 41, oFirst_Bad_Nut = 42, oGood = 0.
  - A second mismatch (7 vs 8) leaves oFirst_Bad_* unchanged.
- DEPTH = 4: push 5 values with no DUT strobes -> oOverflow = 1 after the 5th, oPending = 4.
  - Then push and pop together -> oPending stays 4, no new error.
- DUT strobe alone with an empty FIFO -> oUnderflow = 1, no counter change.
- DUT and NUT strobe together with an empty FIFO, both 9 -> match via bypass, oPending = 0.
- STOP_ON_FAIL = 1, mismatch 3 vs 4, then 2 matching pairs -> oMatch_Count stays 0.
  - After iClear pulse -> all counters and flags 0, state CHECKING.
- With SCOREBOARD_TIMEOUT_EN and TIMEOUT_CYC = 16: one push, no DUT strobe for 16 cycles -> oTimeout = 1.
  - Reset low mid-operation -> everything returns to reset values.
